fetch_inst_buffer: RTL and testbench
====================================

Name: fetch_inst_buffer

Overview:
- In-order instruction buffer between the fetch stage and the ID_REG decode/issue register.
- Accepts up to two fetched instructions per cycle from IF.
- Presents the two oldest entries as the dual-issue pair (fifo_id_* bundle) consumed by decode.
- Decouples fetch from decode backpressure and is cleared by pipeline flush.

Parameters:
- DEPTH, 8: number of single-instruction entries; power of two, >= 4.
- PTR_W, 3: pointer width, log2(DEPTH).

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- flush  in  1  discard all buffered entries (exception/branch redirect)
- if_readygo  in  1  IF offers a packet this cycle
- fifo_allowin  out  1  buffer can accept a full 2-instruction packet
- if_valid  in  2  per-slot valid of offered packet
- if_inst0, if_inst1  in  32  instructions
- if_pc0, if_pc1  in  32  instruction PCs
- if_pred_taken  in  2  per-slot predicted-taken bit
- if_excp  in  2  per-slot fetch exception flag
- if_ecode  in  7  exception code, applies to every excepting slot of the packet
- id_readygo  out  1  at least one entry presented to decode
- id_allowin  in  1  decode/ID_REG accepts the presented pair
- fifo_id_valid  out  2  slot valid of presented pair
- fifo_id_inst0, fifo_id_inst1  out  32  head and head+1 instructions
- fifo_id_pc0, fifo_id_pc1  out  32  their PCs
- fifo_id_branch_flag  out  2  per-slot predicted-taken
- fifo_id_excp_flag  out  2  per-slot exception flag
- fifo_id_exception  out  7  code of slot 0 if excepting, else slot 1 if valid and excepting, else 0
- fifo_id_badv  out  32  PC of the slot selected for fifo_id_exception, else 0

Behaviour:
- Entry contents: {pc, inst, pred_taken, excp, ecode}.
- State: head pointer, tail pointer (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Reset (aresetn=0 at posedge): head=tail=count=0.
  - fifo_allowin forced 0 while aresetn=0.
  - All fifo_id_* outputs, fifo_id_valid and id_readygo read 0, because of the empty-gating rule below.
- Output gating: every fifo_id_* data field is driven to 0 when its slot is not valid. Outputs are combinational reads of the head entries (0-cycle latency from storage).
- Slot valid:
  - slot0 = count>=1.
  - slot1 = count>=2 AND head entry excp=0. An excepting instruction always issues alone.
- id_readygo = slot0 valid.
- npop = (id_readygo & id_allowin) ? popcount(fifo_id_valid) : 0. Pop advances head by npop.
- fifo_allowin = (DEPTH - count) >= 2. It uses the registered count only; a same-cycle pop does not raise it.
- Push occurs when if_readygo & fifo_allowin:
  - Valid slots are written in order: slot0 first, then slot1.
  - if_valid=2'b10 is compacted (slot1 written at tail).
  - npush = popcount(if_valid); tail advances by npush.
  - if_valid=00 with if_readygo pushes nothing.
- Simultaneous push and pop: count_next = count + npush - npop. Both pointers update in the same cycle; no bypass from push to output (new entries are visible the next cycle).
- Flush (aresetn=1, flush=1): head=tail=count=0 next cycle; push and pop in that cycle are ignored. Outputs still reflect the pre-flush state combinationally during the flush cycle. Decode is responsible for ignoring them.
- Reset has priority over flush, flush over push/pop.
- Wrap-around: head+1 and tail+1 indices are taken modulo DEPTH. A pair straddling index DEPTH-1/0 must present and pop correctly.
- No overflow possible: push only when >=2 free. Pop never exceeds count (slot validity derives from count).

Test Plan:
- Reset, then push {pc0=0x1c000000, pc1=0x1c000004, valid=11} with id_allowin=0 → next cycle fifo_id_valid=11, pc0/pc1 match, count=2; hold 3 cycles, outputs stable.
- Fill: push 4 packets, id_allowin=0 → after the 3rd packet fifo_allowin=1 (count=6), after the 4th fifo_allowin=0 (count=8); the 5th offer is not accepted.
- Wrap: DEPTH=8, push/pop continuously 2-in/2-out for 10 cycles → PCs emerge strictly in order across index 7→0; count stays constant.
- Exception split: push slot0 excp=1, ecode=0x08, pc=0x1c000010, plus a clean slot1 → fifo_id_valid=01, exception=0x08, badv=0x1c000010; after one pop, slot1 is presented alone as slot0.
- Compaction: push if_valid=10 with pc1=0x1c000024 → fifo_id_pc0=0x1c000024, fifo_id_valid=01, count=1.
- Flush with count=5, concurrent push and pop → next cycle count=0, fifo_id_valid=00, id_readygo=0, fifo_allowin=1; mid-operation aresetn=0 gives the same result.

Source files
------------

// File: rtl/fetch_inst_buffer_if.sv
// Fetch-to-decode instruction buffer bus: IF offer side, decode pair side, flush.
interface fetch_inst_buffer_if;
  logic        flush;
  // fetch side
  logic        if_readygo;
  logic        fifo_allowin;
  logic [1:0]  if_valid;
  logic [31:0] if_inst0;
  logic [31:0] if_inst1;
  logic [31:0] if_pc0;
  logic [31:0] if_pc1;
  logic [1:0]  if_pred_taken;
  logic [1:0]  if_excp;
  logic [6:0]  if_ecode;
  // decode side
  logic        id_readygo;
  logic        id_allowin;
  logic [1:0]  fifo_id_valid;
  logic [31:0] fifo_id_inst0;
  logic [31:0] fifo_id_inst1;
  logic [31:0] fifo_id_pc0;
  logic [31:0] fifo_id_pc1;
  logic [1:0]  fifo_id_branch_flag;
  logic [1:0]  fifo_id_excp_flag;
  logic [6:0]  fifo_id_exception;
  logic [31:0] fifo_id_badv;

  // buffer view
  modport slave (
    input  flush, if_readygo, if_valid, if_inst0, if_inst1, if_pc0, if_pc1,
           if_pred_taken, if_excp, if_ecode, id_allowin,
    output fifo_allowin, id_readygo, fifo_id_valid, fifo_id_inst0, fifo_id_inst1,
           fifo_id_pc0, fifo_id_pc1, fifo_id_branch_flag, fifo_id_excp_flag,
           fifo_id_exception, fifo_id_badv
  );

  // pipeline / environment view
  modport master (
    output flush, if_readygo, if_valid, if_inst0, if_inst1, if_pc0, if_pc1,
           if_pred_taken, if_excp, if_ecode, id_allowin,
    input  fifo_allowin, id_readygo, fifo_id_valid, fifo_id_inst0, fifo_id_inst1,
           fifo_id_pc0, fifo_id_pc1, fifo_id_branch_flag, fifo_id_excp_flag,
           fifo_id_exception, fifo_id_badv
  );
endinterface

// File: rtl/fetch_inst_buffer.sv
// In-order dual-issue instruction buffer between IF and ID_REG.
// Accepts up to two instructions per cycle, presents the two oldest as a pair.

// One presented slot: zeroes every field when the slot is not valid.
module fib_slot (
  input  logic        vld,
  input  logic [31:0] ent_pc,
  input  logic [31:0] ent_inst,
  input  logic        ent_pred,
  input  logic        ent_excp,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        pred,
  output logic        excp
);
  assign pc   = vld ? ent_pc   : '0;
  assign inst = vld ? ent_inst : '0;
  assign pred = vld & ent_pred;
  assign excp = vld & ent_excp;
endmodule

module fetch_inst_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic               aclk,
  input logic               aresetn,
  fetch_inst_buffer_if.slave bus
);
  localparam int NUM_SLOTS = 2;
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEPTH - 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic        excp;
    logic [6:0]  ecode;
  } ent_t;

  ent_t             mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] head1, tail1;
  ent_t [NUM_SLOTS-1:0] hd;
  ent_t [NUM_SLOTS-1:0] in_ent;
  ent_t             wr0;
  logic [NUM_SLOTS-1:0] slot_vld;
  logic             push, pop_en;
  logic [1:0]       npush, npop;

  logic [NUM_SLOTS-1:0][31:0] out_pc, out_inst;
  logic [NUM_SLOTS-1:0]       out_pred, out_excp;

  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;

  assign hd[0] = mem[head];
  assign hd[1] = mem[head1];

  // Excepting head issues alone so decode never pairs past a fault.
  assign slot_vld[0] = (count != '0);
  assign slot_vld[1] = (count >= CNT_TWO) & ~hd[0].excp;

  // Room check uses the registered count; a same-cycle pop does not help.
  assign bus.fifo_allowin = aresetn & (count <= CNT_LIM);
  assign push  = bus.if_readygo & bus.fifo_allowin;
  assign npush = push ? ({1'b0, bus.if_valid[0]} + {1'b0, bus.if_valid[1]}) : 2'd0;

  assign bus.id_readygo = slot_vld[0];
  assign pop_en = slot_vld[0] & bus.id_allowin;
  assign npop   = pop_en ? ({1'b0, slot_vld[0]} + {1'b0, slot_vld[1]}) : 2'd0;

  assign in_ent[0] = {bus.if_pc0, bus.if_inst0, bus.if_pred_taken[0], bus.if_excp[0], bus.if_ecode};
  assign in_ent[1] = {bus.if_pc1, bus.if_inst1, bus.if_pred_taken[1], bus.if_excp[1], bus.if_ecode};
  // Compaction: a lone slot1 instruction lands at tail.
  assign wr0 = bus.if_valid[0] ? in_ent[0] : in_ent[1];

  // Pointer/count update; reset beats flush, flush beats push/pop.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(npop);
      tail  <= tail + PTR_W'(npush);
      count <= count + CNT_W'(npush) - CNT_W'(npop);
    end
  end

  // Entry storage writes; data needs no reset since outputs are valid-gated.
  always_ff @(posedge aclk) begin
    if (aresetn && !bus.flush) begin
      if (npush != 2'd0) mem[tail]  <= wr0;
      if (npush == 2'd2) mem[tail1] <= in_ent[1];
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    fib_slot u_slot (
      .vld      (slot_vld[i]),
      .ent_pc   (hd[i].pc),
      .ent_inst (hd[i].inst),
      .ent_pred (hd[i].pred),
      .ent_excp (hd[i].excp),
      .pc       (out_pc[i]),
      .inst     (out_inst[i]),
      .pred     (out_pred[i]),
      .excp     (out_excp[i])
    );
  end

  assign bus.fifo_id_valid       = slot_vld;
  assign bus.fifo_id_pc0         = out_pc[0];
  assign bus.fifo_id_pc1         = out_pc[1];
  assign bus.fifo_id_inst0       = out_inst[0];
  assign bus.fifo_id_inst1       = out_inst[1];
  assign bus.fifo_id_branch_flag = out_pred;
  assign bus.fifo_id_excp_flag   = out_excp;

  // Report the oldest excepting valid slot's code and PC.
  always_comb begin
    bus.fifo_id_exception = '0;
    bus.fifo_id_badv      = '0;
    if (slot_vld[0] & hd[0].excp) begin
      bus.fifo_id_exception = hd[0].ecode;
      bus.fifo_id_badv      = hd[0].pc;
    end else if (slot_vld[1] & hd[1].excp) begin
      bus.fifo_id_exception = hd[1].ecode;
      bus.fifo_id_badv      = hd[1].pc;
    end
  end
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Directed + random bench for fetch_inst_buffer with a queue-based reference model.
module tb_fetch_inst_buffer;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic        excp;
    logic [6:0]  ecode;
  } ent_t;

  logic aclk = 1'b0;
  logic aresetn;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] pc_ctr;
  ent_t q[$];

  fetch_inst_buffer_if bus ();

  fetch_inst_buffer #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model queue contents.
  task automatic check_all();
    ent_t e0, e1;
    logic v0, v1;
    logic [6:0]  xc;
    logic [31:0] bv;
    e0 = (q.size() > 0) ? q[0] : '0;
    e1 = (q.size() > 1) ? q[1] : '0;
    v0 = (q.size() >= 1);
    v1 = (q.size() >= 2) && !e0.excp;
    xc = '0; bv = '0;
    if (v0 && e0.excp) begin xc = e0.ecode; bv = e0.pc; end
    else if (v1 && e1.excp) begin xc = e1.ecode; bv = e1.pc; end
    chk("allowin", 32'(bus.fifo_allowin), 32'(aresetn && q.size() <= DEPTH - 2));
    chk("readygo", 32'(bus.id_readygo), 32'(v0));
    chk("valid",   32'(bus.fifo_id_valid), 32'({v1, v0}));
    chk("pc0",     bus.fifo_id_pc0,   v0 ? e0.pc : 32'h0);
    chk("pc1",     bus.fifo_id_pc1,   v1 ? e1.pc : 32'h0);
    chk("inst0",   bus.fifo_id_inst0, v0 ? e0.inst : 32'h0);
    chk("inst1",   bus.fifo_id_inst1, v1 ? e1.inst : 32'h0);
    chk("bflag",   32'(bus.fifo_id_branch_flag), 32'({v1 & e1.pred, v0 & e0.pred}));
    chk("eflag",   32'(bus.fifo_id_excp_flag),   32'({v1 & e1.excp, v0 & e0.excp}));
    chk("ecode",   32'(bus.fifo_id_exception), 32'(xc));
    chk("badv",    bus.fifo_id_badv, bv);
  endtask

  // One clock: model decides from pre-edge state, updates at edge, then compares.
  task automatic cyc();
    logic acc, v0, v1;
    int   npop;
    ent_t in0, in1;
    acc  = aresetn && bus.if_readygo && (q.size() <= DEPTH - 2);
    v0   = (q.size() >= 1);
    v1   = (q.size() >= 2) && !q[0].excp;
    npop = (v0 && bus.id_allowin) ? (int'(v0) + int'(v1)) : 0;
    in0  = {bus.if_pc0, bus.if_inst0, bus.if_pred_taken[0], bus.if_excp[0], bus.if_ecode};
    in1  = {bus.if_pc1, bus.if_inst1, bus.if_pred_taken[1], bus.if_excp[1], bus.if_ecode};
    @(posedge aclk);
    if (!aresetn || bus.flush) q.delete();
    else begin
      for (int k = 0; k < npop; k++) void'(q.pop_front());
      if (acc && bus.if_valid[0]) q.push_back(in0);
      if (acc && bus.if_valid[1]) q.push_back(in1);
    end
    #1 check_all();
  endtask

  task automatic offer(input logic [1:0] v, input logic [1:0] ex, input logic [6:0] ec,
                       input logic [1:0] pr);
    bus.if_readygo    = 1'b1;
    bus.if_valid      = v;
    bus.if_excp       = ex;
    bus.if_ecode      = ec;
    bus.if_pred_taken = pr;
    bus.if_pc0        = pc_ctr;
    bus.if_pc1        = pc_ctr + 32'd4;
    bus.if_inst0      = pc_ctr ^ 32'h5a5a_0013;
    bus.if_inst1      = (pc_ctr + 32'd4) ^ 32'h5a5a_0013;
    pc_ctr            = pc_ctr + 32'd8;
  endtask

  task automatic idle();
    bus.if_readygo = 1'b0;
    bus.if_valid   = 2'b00;
  endtask

  initial begin
    aresetn = 1'b0;
    pc_ctr  = 32'h1c00_0000;
    bus.flush = 1'b0;
    bus.id_allowin = 1'b0;
    bus.if_excp = '0; bus.if_ecode = '0; bus.if_pred_taken = '0;
    bus.if_pc0 = '0; bus.if_pc1 = '0; bus.if_inst0 = '0; bus.if_inst1 = '0;
    idle();
    cyc(); cyc();
    chk("rst_allowin", 32'(bus.fifo_allowin), 32'h0);
    aresetn = 1'b1;
    cyc();
    chk("post_rst_allowin", 32'(bus.fifo_allowin), 32'h1);

    // single pair, held by decode backpressure
    offer(2'b11, 2'b00, 7'h0, 2'b01); cyc(); idle();
    chk("s1_pc0", bus.fifo_id_pc0, 32'h1c00_0000);
    chk("s1_pc1", bus.fifo_id_pc1, 32'h1c00_0004);
    repeat (3) cyc();
    chk("s1_hold_valid", 32'(bus.fifo_id_valid), 32'h3);

    // fill to DEPTH; fifth offer refused
    offer(2'b11, 2'b00, 7'h0, 2'b10); cyc();
    offer(2'b11, 2'b00, 7'h0, 2'b00); cyc();
    chk("fill6_allowin", 32'(bus.fifo_allowin), 32'h1);
    offer(2'b11, 2'b00, 7'h0, 2'b11); cyc();
    chk("fill8_allowin", 32'(bus.fifo_allowin), 32'h0);
    offer(2'b11, 2'b00, 7'h0, 2'b00); cyc(); idle();
    chk("full_pc0", bus.fifo_id_pc0, 32'h1c00_0000);
    bus.id_allowin = 1'b1;
    repeat (4) cyc();
    chk("drained", 32'(bus.id_readygo), 32'h0);

    // continuous 2-in/2-out across the index wrap
    bus.id_allowin = 1'b0;
    offer(2'b11, 2'b00, 7'h0, 2'b00); cyc();
    bus.id_allowin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(2'b11, 2'b00, 7'h0, 2'(i)); cyc();
      chk("wrap_valid", 32'(bus.fifo_id_valid), 32'h3);
    end
    idle(); repeat (2) cyc();

    // excepting slot0 issues alone
    bus.id_allowin = 1'b0;
    pc_ctr = 32'h1c00_0010;
    offer(2'b11, 2'b01, 7'h08, 2'b00); cyc(); idle();
    chk("exc_valid", 32'(bus.fifo_id_valid), 32'h1);
    chk("exc_code",  32'(bus.fifo_id_exception), 32'h08);
    chk("exc_badv",  bus.fifo_id_badv, 32'h1c00_0010);
    bus.id_allowin = 1'b1; cyc(); bus.id_allowin = 1'b0;
    chk("exc_next_pc0", bus.fifo_id_pc0, 32'h1c00_0014);
    chk("exc_next_valid", 32'(bus.fifo_id_valid), 32'h1);
    // excepting slot1 reported from slot1
    offer(2'b11, 2'b10, 7'h0c, 2'b00); cyc(); idle();
    bus.id_allowin = 1'b1; repeat (3) cyc();

    // compaction of a lone slot1 instruction
    bus.id_allowin = 1'b0;
    pc_ctr = 32'h1c00_0020;
    offer(2'b10, 2'b00, 7'h0, 2'b10); cyc(); idle();
    chk("cmp_pc0",   bus.fifo_id_pc0, 32'h1c00_0024);
    chk("cmp_valid", 32'(bus.fifo_id_valid), 32'h1);

    // flush at count=5 with concurrent push and pop
    offer(2'b11, 2'b00, 7'h0, 2'b00); cyc();
    offer(2'b11, 2'b00, 7'h0, 2'b00); cyc();
    bus.flush = 1'b1; bus.id_allowin = 1'b1;
    offer(2'b11, 2'b00, 7'h0, 2'b00); cyc();
    bus.flush = 1'b0; idle(); bus.id_allowin = 1'b0;
    chk("flush_valid",   32'(bus.fifo_id_valid), 32'h0);
    chk("flush_allowin", 32'(bus.fifo_allowin), 32'h1);

    // reset mid-operation
    offer(2'b11, 2'b00, 7'h0, 2'b00); cyc();
    offer(2'b11, 2'b01, 7'h11, 2'b00); cyc();
    aresetn = 1'b0; bus.id_allowin = 1'b1;
    offer(2'b11, 2'b00, 7'h0, 2'b00); cyc();
    chk("rst_mid_readygo", 32'(bus.id_readygo), 32'h0);
    aresetn = 1'b1; idle(); bus.id_allowin = 1'b0;
    cyc();

    // random traffic
    for (int i = 0; i < 200; i++) begin
      offer(2'($urandom), 2'($urandom_range(0, 7) == 0 ? $urandom : 0), 7'($urandom), 2'($urandom));
      bus.if_readygo = ($urandom_range(0, 3) != 0);
      bus.id_allowin = ($urandom_range(0, 2) != 0);
      bus.flush      = ($urandom_range(0, 31) == 0);
      cyc();
    end
    bus.flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
